memseq: RTL and testbench

Byte-serial data-memory sequencer sitting between the processor datapath and the 8-bit external data bus. It is the memory-side end of the load/store controls that `control` produces: memtoreg/memwrite, in/out size, and insign. It accepts one byte, halfword or word access per request and runs it as 1, 2 or 4 byte transactions on the bus. For loads it assembles the bytes little-endian and zero- or sign-extends the result to 32 bits.

---
 rtl/memseq_pkg.sv | 27 ++
 rtl/memseq_ext.sv | 21 ++
 rtl/memseq.sv | 125 ++++++++++++
 tb/tb_memseq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/memseq_pkg.sv
// Shared state codes, access sizes and the latched request record for the
// byte-serial data-memory sequencer.
package memseq_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_XFER = 2'd1,
    MS_DONE = 2'd2,
    MS_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic        sign;
    logic [31:0] wdata;
  } req_t;

  function automatic logic size_ok(input logic [2:0] s);
    return (s == SZ_B) || (s == SZ_H) || (s == SZ_W);
  endfunction

endpackage

// File: rtl/memseq_ext.sv
// Load result extension: little-endian assembly bytes to a 32-bit word,
// zero- or sign-extended by access size (words pass through).
module memseq_ext
  import memseq_pkg::*;
(
  input  logic [2:0]      size,
  input  logic            sign,
  input  logic [3:0][7:0] asm,
  output logic [31:0]     data
);

  always_comb begin
    data = asm;
    case (size)
      SZ_B:    data = {{24{sign & asm[0][7]}}, asm[0]};
      SZ_H:    data = {{16{sign & asm[1][7]}}, asm[1], asm[0]};
      default: data = asm;
    endcase
  end

endmodule

// File: rtl/memseq.sv
// Byte-serial data-memory sequencer: one byte/half/word access per request,
// run as 1/2/4 bus bytes. Optional MEMSEQ_ALIGN_CHECK_EN rejects misaligned
// halves and words with an error pulse instead of running them.
module memseq
  import memseq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_wr,
  input  logic [2:0]    i_size,
  input  logic          i_sign,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [31:0]   o_rdata,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [7:0]    o_bus_wdata,
  input  logic          i_bus_ack,
  input  logic [7:0]    i_bus_rdata
);

  state_t          state;
  req_t            cur;
  logic [1:0]      cnt;
  logic [3:0][7:0] asm_q, asm_nxt, wbytes;
  logic [31:0]     ext_data;
  logic            bad, last;

`ifdef MEMSEQ_ALIGN_CHECK_EN
  assign bad = !size_ok(i_size) ||
               (i_size == SZ_H && i_addr[0]) ||
               (i_size == SZ_W && i_addr[1:0] != 2'b00);
`else
  assign bad = !size_ok(i_size);
`endif

  assign last   = ({1'b0, cnt} == cur.size - 3'd1);
  assign wbytes = cur.wdata;

  // Merge the byte arriving this cycle so the final ack can register the
  // complete result and o_rdata is already valid in the DONE cycle.
  always_comb begin
    asm_nxt      = asm_q;
    asm_nxt[cnt] = i_bus_rdata;
  end

  memseq_ext u_ext (
    .size (cur.size),
    .sign (cur.sign),
    .asm  (asm_nxt),
    .data (ext_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= MS_IDLE;
      cur         <= '0;
      cnt         <= '0;
      asm_q       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (i_req) begin
            o_busy <= 1'b1;
            if (bad) begin
              state <= MS_ERR;
              o_err <= 1'b1;
            end else begin
              state       <= MS_XFER;
              cur         <= '{wr: i_wr, size: i_size, sign: i_sign, wdata: i_wdata};
              cnt         <= '0;
              asm_q       <= '0;
              o_bus_req   <= 1'b1;
              o_bus_we    <= i_wr;
              o_bus_addr  <= i_addr;
              o_bus_wdata <= i_wdata[7:0];
            end
          end
        end
        MS_XFER: begin
          if (i_bus_ack) begin
            asm_q <= asm_nxt;
            if (last) begin
              state     <= MS_DONE;
              o_done    <= 1'b1;
              o_bus_req <= 1'b0;
              o_bus_we  <= 1'b0;
              if (!cur.wr) o_rdata <= ext_data;
            end else begin
              cnt         <= cnt + 2'd1;
              o_bus_addr  <= o_bus_addr + AW'(1);
              o_bus_wdata <= wbytes[cnt + 2'd1];
            end
          end
        end
        MS_DONE, MS_ERR: begin
          state  <= MS_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= MS_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memseq.sv
// Directed bench for memseq: drives the bus by hand, checks every byte,
// completion timing and the extended load result.
module tb_memseq;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, wr = 1'b0, sign = 1'b0;
  logic [2:0]    size = 3'd0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          busy, done, err;
  logic [31:0]   rdata;
  logic          bus_req, bus_we, bus_ack = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata, bus_rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memseq #(.AW(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_wr        (wr),
    .i_size      (size),
    .i_sign      (sign),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rdata     (rdata),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_ack   (bus_ack),
    .i_bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full access with `waits` idle cycles before each byte ack. rbytes holds
  // the bus read bytes little-endian; exp_rd is the hand-computed o_rdata.
  task automatic access(input string tag, input logic w, input logic [2:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rbytes, input int waits,
                        input logic [31:0] exp_rd);
    logic [31:0] exp_a;
    logic [7:0]  exp_wb;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sign = sg; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < int'(sz); i++) begin
      exp_a  = a + i;
      exp_wb = wd[8*i +: 8];
      for (int k = 0; k < waits; k++) begin
        chk({tag, " wait req"},  {31'd0, bus_req}, 32'd1);
        chk({tag, " wait addr"}, bus_addr, exp_a);
        if (w) chk({tag, " wait wdata"}, {24'd0, bus_wdata}, {24'd0, exp_wb});
        @(posedge clk);
        @(negedge clk);
      end
      bus_ack   = 1'b1;
      bus_rdata = rbytes[8*i +: 8];
      chk({tag, " req"},  {31'd0, bus_req}, 32'd1);
      chk({tag, " we"},   {31'd0, bus_we}, {31'd0, w});
      chk({tag, " addr"}, bus_addr, exp_a);
      if (w) chk({tag, " wdata"}, {24'd0, bus_wdata}, {24'd0, exp_wb});
      @(posedge clk);
      @(negedge clk);
      bus_ack = 1'b0;
    end
    chk({tag, " done"},    {31'd0, done}, 32'd1);
    chk({tag, " req off"}, {31'd0, bus_req}, 32'd0);
    chk({tag, " rdata"},   rdata, exp_rd);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic err_access(input string tag, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] exp_rd);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = sz; sign = 1'b0; addr = a;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk({tag, " err"},   {31'd0, err}, 32'd1);
    chk({tag, " nobus"}, {31'd0, bus_req}, 32'd0);
    chk({tag, " rdata"}, rdata, exp_rd);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle"}, {29'd0, busy, err, bus_req}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst outs", {27'd0, busy, done, err, bus_req, bus_we}, 32'd0);
    chk("rst addr", bus_addr, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst wdata", {24'd0, bus_wdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access("wload", 1'b0, 3'd4, 1'b0, 32'h100, 32'h0, 32'h44332211, 0, 32'h44332211);
    access("sbyte", 1'b0, 3'd1, 1'b1, 32'h7,   32'h0, 32'h00000080, 0, 32'hFFFFFF80);
    access("ubyte", 1'b0, 3'd1, 1'b0, 32'h7,   32'h0, 32'h00000080, 0, 32'h00000080);
    access("hstore", 1'b1, 3'd2, 1'b0, 32'h202, 32'hABCD1234, 32'h0, 3, 32'h00000080);
    access("shalf", 1'b0, 3'd2, 1'b1, 32'h40,  32'h0, 32'h00009000, 0, 32'hFFFF9000);
    access("uhalf", 1'b0, 3'd2, 1'b0, 32'h42,  32'h0, 32'h0000F0A5, 1, 32'h0000F0A5);
    access("sword", 1'b0, 3'd4, 1'b1, 32'h80,  32'h0, 32'hF00000FF, 0, 32'hF00000FF);
    access("wstore", 1'b1, 3'd4, 1'b0, 32'h300, 32'hDEADBEEF, 32'h0, 1, 32'hF00000FF);

    err_access("size3", 3'd3, 32'h10, 32'hF00000FF);
    err_access("size0", 3'd0, 32'h10, 32'hF00000FF);
    err_access("size6", 3'd6, 32'h10, 32'hF00000FF);

`ifdef MEMSEQ_ALIGN_CHECK_EN
    err_access("mis word", 3'd4, 32'h101, 32'hF00000FF);
    err_access("mis half", 3'd2, 32'h203, 32'hF00000FF);
`else
    access("mis word", 1'b0, 3'd4, 1'b0, 32'h101, 32'h0, 32'h04030201, 0, 32'h04030201);
    access("wrap", 1'b0, 3'd2, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0000BEEF, 0, 32'h0000BEEF);
`endif

    // Abort a word load after its second byte.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 3'd4; sign = 1'b0; addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_ack = 1'b1; bus_rdata = 8'hC0 + 8'(i);
      @(posedge clk);
      @(negedge clk);
      bus_ack = 1'b0;
    end
    chk("pre rst req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst", {30'd0, bus_req, busy}, 32'd0);
    chk("rst rdata2", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access("post rst", 1'b0, 3'd1, 1'b1, 32'h600, 32'h0, 32'h0000005A, 0, 32'h0000005A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
